// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_pkg
//  Purpose  : Shared definitions for the bit-serial adder: FSM state
//             encodings and the legal operand-width range.
//  Revision : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder
//  Purpose  : Single-bit combinational full adder cell.
//  Ports    : a, b  - addend bits
//             c     - carry in
//             sum   - a ^ b ^ c
//             carry - carry out
//  Revision : 1.0  initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial WIDTH-bit adder. Captures two operands and a carry
//             in on an accepted start, then pushes one bit pair per clock,
//             LSB first, through a single full_adder cell with the carry held
//             in a flop. Publishes {cout,sum} = op_a + op_b + cin with a
//             one-cycle done pulse.
//  Ports    : clk    - clock, rising edge
//             rst_n  - asynchronous active-low reset
//             start  - request, sampled only in IDLE or DONE
//             op_a   - operand A (captured on accepted start)
//             op_b   - operand B (captured on accepted start)
//             cin    - carry in (captured on accepted start)
//             busy   - high while the addition is running
//             done   - one-cycle pulse when sum/cout are updated
//             sum    - registered result, held until next completion
//             cout   - registered carry out, held until next completion
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("serial_adder: WIDTH out of range");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic               r_c_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic               w_fa_sum;
    logic               w_fa_carry;
    logic [WIDTH-1:0]   w_res_next;

    // Requests are only honoured when no addition is in flight; DONE counts
    // as free so a held start gives back-to-back operation.
    assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_last   = (r_cnt == c_cnt_last);

    full_adder u_fa (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .c     (r_c_q),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 has reached
    // the LSB position. A one-bit adder has nothing to shift down.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_fa_sum;
        end else begin : g_res_wn
            assign w_res_next = {w_fa_sum, r_res_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_c_q    <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= op_a;
            r_b_sh   <= op_b;
            r_c_q    <= cin;
            r_cnt    <= '0;
            r_res_sh <= '0;
        end else if (r_state == ST_RUN) begin
            r_res_sh <= w_res_next;
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_c_q    <= w_fa_carry;
            r_cnt    <= r_cnt + CNT_W'(1);
            // Outputs only move on the final shift so no partial result
            // is ever visible.
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_fa_carry;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op_a(a8), .op_b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(a1), .op_b(b1),
        .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[8];

    // Called at #1 after an edge with the DUT in IDLE or DONE.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic eco, input string name);
        int nb;
        bit seen;
        nb   = 0;
        seen = 0;
        start8 = 1'b1; a8 = a; b8 = b; cin8 = ci;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                seen = 1;
                break;
            end
            if (busy8) nb++;
            @(posedge clk); #1;
        end
        chk({name, " done seen"}, 64'(seen), 64'd1);
        chk({name, " busy cycles"}, 64'(nb), 64'd8);
        chk({name, " sum"}, 64'(sum8), 64'(es));
        chk({name, " cout"}, 64'(cout8), 64'(eco));
        @(posedge clk); #1;
        chk({name, " done width"}, 64'(done8), 64'd0);
    endtask

    // Random-phase scoreboards
    bit         mon_en = 0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];
    int         acc8 = 0, dn8 = 0, acc1 = 0, dn1 = 0;

    always @(posedge clk) begin
        logic [8:0] e;
        #1;
        if (mon_en && done8) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL rand8 unexpected done: got done=1 expected none");
            end else begin
                e = q8.pop_front();
                chk("rand8 sum", 64'(sum8), 64'(e[7:0]));
                chk("rand8 cout", 64'(cout8), 64'(e[8]));
                dn8++;
            end
        end
    end

    always @(posedge clk) begin
        logic [1:0] e;
        #1;
        if (mon_en && done1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL rand1 unexpected done: got done=1 expected none");
            end else begin
                e = q1.pop_front();
                chk("rand1 sum", 64'(sum1), 64'(e[0]));
                chk("rand1 cout", 64'(cout1), 64'(e[1]));
                dn1++;
            end
        end
    end

    task automatic rand8(input int n);
        int gap, w;
        logic [7:0] a, b;
        logic ci;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (busy8 && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 50) begin
                checks++; errors++;
                $display("FAIL rand8 timeout: busy stuck got 1 expected 0");
                break;
            end
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
            start8 = 1'b1; a8 = a; b8 = b; cin8 = ci;
            q8.push_back(9'(a) + 9'(b) + 9'(ci));
            acc8++;
            @(posedge clk); #1;
            start8 = 1'b0;
        end
        w = 0;
        while (busy8 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #2;
    endtask

    task automatic rand1(input int n);
        int gap, w;
        logic a, b, ci;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (busy1 && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 50) begin
                checks++; errors++;
                $display("FAIL rand1 timeout: busy stuck got 1 expected 0");
                break;
            end
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            a = 1'($urandom); b = 1'($urandom); ci = 1'($urandom);
            start1 = 1'b1; a1 = a; b1 = b; cin1 = ci;
            q1.push_back(2'(a) + 2'(b) + 2'(ci));
            acc1++;
            @(posedge clk); #1;
            start1 = 1'b0;
        end
        w = 0;
        while (busy1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0};

        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #2;
        chk("reset busy", 64'(busy8), 64'd0);
        chk("reset done", 64'(done8), 64'd0);
        chk("reset sum", 64'(sum8), 64'd0);
        chk("reset cout", 64'(cout8), 64'd0);
        chk("reset w1 busy/done", 64'({busy1, done1}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven single operations
        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co,
                $sformatf("vec%0d", i));
        end

        // start during RUN must be ignored
        start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'hEE; b8 = 8'hEE; cin8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                ndone++;
                chk("ignore-start sum", 64'(sum8), 64'h10);
                chk("ignore-start cout", 64'(cout8), 64'd0);
            end
            @(posedge clk); #1;
        end
        chk("ignore-start done count", 64'(ndone), 64'd1);
        chk("ignore-start sum held", 64'(sum8), 64'h10);

        // Asynchronous reset in the 4th RUN cycle
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrun busy before reset", 64'(busy8), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun reset busy", 64'(busy8), 64'd0);
        chk("midrun reset done", 64'(done8), 64'd0);
        chk("midrun reset sum", 64'(sum8), 64'd0);
        chk("midrun reset cout", 64'(cout8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "post-reset");

        // Random traffic on both widths, including back-to-back from DONE
        mon_en = 1;
        fork
            rand8(300);
            rand1(200);
        join
        mon_en = 0;
        chk("rand8 done count", 64'(dn8), 64'(acc8));
        chk("rand8 queue empty", 64'(q8.size()), 64'd0);
        chk("rand1 done count", 64'(dn1), 64'(acc1));
        chk("rand1 queue empty", 64'(q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
